// File: rtl/vending_pkg.sv
// Shared types and default parameters for the multi-item vending machine.
package vending_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CREDIT,
    ST_DISPENSE,
    ST_CHANGE
  } vm_state_e;

  localparam int unsigned NUM_ITEMS_DEF  = 4;
  localparam int unsigned CREDIT_W_DEF   = 8;
  localparam int unsigned MAX_CREDIT_DEF = 200;
  localparam int unsigned STOCK_W_DEF    = 4;
  localparam int unsigned STOCK_INIT_DEF = 5;

endpackage

// File: rtl/vm_stock_bank.sv
// Per-item stock counters: decrement on sale, refill on restock (restock wins),
// plus a level zero flag per item.
module vm_stock_bank #(
  parameter int unsigned NUM_ITEMS  = 4,
  parameter int unsigned STOCK_W    = 4,
  parameter int unsigned STOCK_INIT = 5,
  parameter int unsigned SEL_W      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dec_i,
  input  logic [SEL_W-1:0]     dec_sel_i,
  input  logic                 restock_i,
  input  logic [SEL_W-1:0]     restock_sel_i,
  output logic [NUM_ITEMS-1:0] zero_o
);

  logic [NUM_ITEMS-1:0][STOCK_W-1:0] stock_q;

  for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_item
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stock_q[g] <= STOCK_W'(STOCK_INIT);
      end else if (restock_i && restock_sel_i == SEL_W'(g)) begin
        stock_q[g] <= STOCK_W'(STOCK_INIT);
      end else if (dec_i && dec_sel_i == SEL_W'(g) && stock_q[g] != '0) begin
        stock_q[g] <= stock_q[g] - 1'b1;
      end
    end

    assign zero_o[g] = (stock_q[g] == '0);
  end

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-item vending controller: credit accumulation, sale, change/refund and
// registered one-cycle status pulses. Stock lives in vm_stock_bank.
module vending_machine_multi
  import vending_pkg::*;
#(
  parameter int unsigned NUM_ITEMS  = NUM_ITEMS_DEF,
  parameter int unsigned CREDIT_W   = CREDIT_W_DEF,
  parameter int unsigned MAX_CREDIT = MAX_CREDIT_DEF,
  parameter int unsigned STOCK_W    = STOCK_W_DEF,
  parameter int unsigned STOCK_INIT = STOCK_INIT_DEF,
  localparam int unsigned SEL_W     = $clog2(NUM_ITEMS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          coin_valid,
  input  logic [CREDIT_W-1:0]           coin_value,
  input  logic                          buy,
  input  logic [SEL_W-1:0]              buy_sel,
  input  logic                          cancel,
  input  logic                          restock,
  input  logic [SEL_W-1:0]              restock_sel,
  input  logic [NUM_ITEMS*CREDIT_W-1:0] prices,
  output logic [CREDIT_W-1:0]           credit,
  output logic                          dispense,
  output logic [SEL_W-1:0]              dispense_item,
  output logic                          change_valid,
  output logic [CREDIT_W-1:0]           change_amount,
  output logic                          coin_reject,
  output logic                          err_sold_out,
  output logic                          err_funds,
  output logic [NUM_ITEMS-1:0]          sold_out
);

  vm_state_e               state_q, state_d;
  logic [CREDIT_W-1:0]     credit_q, credit_d;
  logic                    dispense_q, dispense_d;
  logic [SEL_W-1:0]        item_q, item_d;
  logic                    chg_vld_q, chg_vld_d;
  logic [CREDIT_W-1:0]     chg_amt_q, chg_amt_d;
  logic                    coin_rej_q, coin_rej_d;
  logic                    err_so_q, err_so_d;
  logic                    err_f_q, err_f_d;
  logic                    dec;
  logic [NUM_ITEMS-1:0]    zero_w;

  logic [NUM_ITEMS-1:0][CREDIT_W-1:0] price_tbl;
  logic [CREDIT_W-1:0]                price;
  logic [CREDIT_W:0]                  coin_sum;

  assign price_tbl = prices;
  assign price     = price_tbl[buy_sel];
  // One extra bit so a large coin on a large credit cannot wrap past the cap.
  assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_value};

  vm_stock_bank #(
    .NUM_ITEMS (NUM_ITEMS),
    .STOCK_W   (STOCK_W),
    .STOCK_INIT(STOCK_INIT),
    .SEL_W     (SEL_W)
  ) u_stock (
    .clk          (clk),
    .rst          (rst),
    .dec_i        (dec),
    .dec_sel_i    (buy_sel),
    .restock_i    (restock),
    .restock_sel_i(restock_sel),
    .zero_o       (zero_w)
  );

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    dispense_d = 1'b0;
    item_d     = '0;
    chg_vld_d  = 1'b0;
    chg_amt_d  = '0;
    coin_rej_d = 1'b0;
    err_so_d   = 1'b0;
    err_f_d    = 1'b0;
    dec        = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_CREDIT: begin
        if (cancel) begin
          coin_rej_d = coin_valid;
          if (credit_q != '0) begin
            state_d   = ST_CHANGE;
            chg_vld_d = 1'b1;
            chg_amt_d = credit_q;
          end
        end else if (buy) begin
          coin_rej_d = coin_valid;
          if (zero_w[buy_sel]) begin
            err_so_d = 1'b1;
          end else if (credit_q < price) begin
            err_f_d = 1'b1;
          end else begin
            credit_d   = credit_q - price;
            dec        = 1'b1;
            state_d    = ST_DISPENSE;
            dispense_d = 1'b1;
            item_d     = buy_sel;
          end
        end else if (coin_valid) begin
          if (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT)) begin
            credit_d = coin_sum[CREDIT_W-1:0];
            if (coin_sum != '0) state_d = ST_CREDIT;
          end else begin
            coin_rej_d = 1'b1;
          end
        end
      end
      ST_DISPENSE: begin
        coin_rej_d = coin_valid;
        if (credit_q != '0) begin
          state_d   = ST_CHANGE;
          chg_vld_d = 1'b1;
          chg_amt_d = credit_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHANGE: begin
        coin_rej_d = coin_valid;
        credit_d   = '0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      credit_q   <= '0;
      dispense_q <= 1'b0;
      item_q     <= '0;
      chg_vld_q  <= 1'b0;
      chg_amt_q  <= '0;
      coin_rej_q <= 1'b0;
      err_so_q   <= 1'b0;
      err_f_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      dispense_q <= dispense_d;
      item_q     <= item_d;
      chg_vld_q  <= chg_vld_d;
      chg_amt_q  <= chg_amt_d;
      coin_rej_q <= coin_rej_d;
      err_so_q   <= err_so_d;
      err_f_q    <= err_f_d;
    end
  end

  assign credit        = credit_q;
  assign dispense      = dispense_q;
  assign dispense_item = item_q;
  assign change_valid  = chg_vld_q;
  assign change_amount = chg_amt_q;
  assign coin_reject   = coin_rej_q;
  assign err_sold_out  = err_so_q;
  assign err_funds     = err_f_q;
  assign sold_out      = zero_w;

endmodule
